uns_acc_sel: RTL and testbench
==============================

Name: uns_acc_sel

Overview:
- Registered unsigned accumulator with input-select control.
- Each clock, adds a selected combination of two narrow unsigned operands into a wider running sum, or holds the sum.
- Exposes the sum and a carry/overflow flag.
- Used as a small datapath block fed by configuration/stimulus registers; standalone, no handshake.

Parameters:
- DATA_W, 3, width of each unsigned input operand.
- ACC_W, 6, width of accumulator register and o_data; must satisfy ACC_W > DATA_W.

Ports:
- clk  input  1  rising-edge clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_data1  input  DATA_W  unsigned operand 1.
- i_data2  input  DATA_W  unsigned operand 2.
- i_sel  input  2  operation select.
- o_data  output  ACC_W  accumulator value (registered).
- o_carry  output  1  carry out of the most recent accumulation (registered).

Behaviour:
- One clock, clk; reset is asynchronous and active-low (i_rst_n), the only reset; deassertion is sampled on the next clk rising edge.
- While i_rst_n = 0: acc = 0, o_carry = 0, immediately and independent of clk.
- On each clk rising edge with i_rst_n = 1, the increment is selected by i_sel:
  - 2'b00: inc = i_data1 + i_data2 (DATA_W+1 bits, zero-extended).
  - 2'b01: inc = i_data1.
  - 2'b10: inc = i_data2.
  - 2'b11: hold; acc unchanged, o_carry <= 0.
- For i_sel != 2'b11: {carry, sum} = acc + inc, computed in ACC_W+1 bits; acc <= sum[ACC_W-1:0]; o_carry <= carry.
- o_data = acc directly, with no combinational path from inputs.
- Latency: an input change is visible on o_data after one rising edge.
- Wrap-around (default build): the sum is modulo 2^ACC_W. Example: acc = 62, inc = 3 -> acc = 1, o_carry = 1 for that cycle; the next non-overflowing add clears o_carry.
- o_carry is not sticky; it reflects only the last update.
- Reset mid-operation: acc and o_carry clear asynchronously; accumulation restarts from 0 on the first edge after release.
- i_sel and data are sampled only at the clk edge; glitches between edges have no effect.
- All arithmetic is unsigned; no X propagation from the hold path.

Optional Feature:
- Macro UNS_ACC_SAT_EN.
- Defined: saturating mode. If acc + inc >= 2^ACC_W, acc <= 2^ACC_W-1 and o_carry <= 1 (overflow/saturated flag). acc stays at max on further adds, with o_carry = 1 each such cycle. Hold (11) still clears o_carry.
- Undefined: modulo wrap-around as described in Behaviour.

Decomposition:
- Shared package uns_acc_pkg:
  - localparam constants for the i_sel encodings: SEL_SUM = 2'b00, SEL_D1 = 2'b01, SEL_D2 = 2'b10, SEL_HOLD = 2'b11.
  - Default widths DATA_W = 3, ACC_W = 6.
- One natural sub-module, uns_acc_inc_mux: combinational increment selector producing the zero-extended inc and a hold flag.
- The top holds the adder, the optional saturation logic and the registers.

Test Plan:
- Reset: assert i_rst_n = 0 mid-run with acc nonzero -> o_data = 0 and o_carry = 0 immediately, without a clock edge.
- i_data1 = 1, i_data2 = 2, i_sel = 00, 5 edges after reset release -> o_data = 15, o_carry = 0.
- Reset, then i_sel = 01, same data, 5 edges -> o_data = 5.
- Reset, then i_sel = 10, 5 edges -> o_data = 10.
- Hold: from o_data = 10, i_sel = 11 for 10 edges -> o_data = 10 and o_carry = 0 throughout.
- Overflow with i_data1 = 7, i_data2 = 7, i_sel = 00 from 0:
  - Default build: after 5 edges o_data = 6 and o_carry = 1 on that edge (70 mod 64); next edge o_data = 20, o_carry = 0.
  - UNS_ACC_SAT_EN build: o_data = 63 and o_carry = 1 from edge 5 on.

Source files
------------

// File: rtl/uns_acc_pkg.sv
// ============================================================================
// Module : uns_acc_pkg
// Brief  : Shared select encodings and default widths for uns_acc_sel.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uns_acc_pkg;

  localparam logic [1:0] SEL_SUM  = 2'b00;
  localparam logic [1:0] SEL_D1   = 2'b01;
  localparam logic [1:0] SEL_D2   = 2'b10;
  localparam logic [1:0] SEL_HOLD = 2'b11;

  localparam int DATA_W_DEF = 3;
  localparam int ACC_W_DEF  = 6;

endpackage

`default_nettype wire

// File: rtl/uns_acc_inc_mux.sv
// ============================================================================
// Module : uns_acc_inc_mux
// Brief  : Combinational increment selector; yields zero-extended inc + hold.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uns_acc_inc_mux
  import uns_acc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] i_data1,
  input  logic [DATA_W-1:0] i_data2,
  input  logic [1:0]        i_sel,
  output logic [DATA_W:0]   o_inc,
  output logic              o_hold
);

  always_comb begin
    o_inc  = '0;
    o_hold = 1'b0;
    case (i_sel)
      SEL_SUM:  o_inc  = {1'b0, i_data1} + {1'b0, i_data2};
      SEL_D1:   o_inc  = {1'b0, i_data1};
      SEL_D2:   o_inc  = {1'b0, i_data2};
      default:  o_hold = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/uns_acc_sel.sv
// ============================================================================
// Module : uns_acc_sel
// Brief  : Registered unsigned accumulator with input select and carry flag.
//          Define UNS_ACC_SAT_EN for saturating instead of wrap-around adds.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uns_acc_sel
  import uns_acc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data1,
  input  logic [DATA_W-1:0] i_data2,
  input  logic [1:0]        i_sel,
  output logic [ACC_W-1:0]  o_data,
  output logic              o_carry
);

  logic [DATA_W:0]  inc;
  logic             hold;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;

  uns_acc_inc_mux #(
    .DATA_W (DATA_W)
  ) u_inc_mux (
    .i_data1 (i_data1),
    .i_data2 (i_data2),
    .i_sel   (i_sel),
    .o_inc   (inc),
    .o_hold  (hold)
  );

  assign sum = {1'b0, acc_q} + {{(ACC_W-DATA_W){1'b0}}, inc};

  always_comb begin
    acc_d   = acc_q;
    carry_d = 1'b0;
    if (!hold) begin
`ifdef UNS_ACC_SAT_EN
      // Clamp at full scale; the carry bit doubles as the saturated flag.
      acc_d   = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
      acc_d   = sum[ACC_W-1:0];
`endif
      carry_d = sum[ACC_W];
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

  assign o_data  = acc_q;
  assign o_carry = carry_q;

endmodule

`default_nettype wire

// File: tb/tb_uns_acc_sel.sv
// ============================================================================
// Module : tb_uns_acc_sel
// Brief  : Directed self-checking bench for uns_acc_sel (either build).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uns_acc_sel;

  localparam int DATA_W = 3;
  localparam int ACC_W  = 6;

  logic              clk = 1'b0;
  logic              i_rst_n;
  logic [DATA_W-1:0] i_data1;
  logic [DATA_W-1:0] i_data2;
  logic [1:0]        i_sel;
  logic [ACC_W-1:0]  o_data;
  logic              o_carry;

  int n_cmp  = 0;
  int n_fail = 0;

  uns_acc_sel #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) dut (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_data1 (i_data1),
    .i_data2 (i_data2),
    .i_sel   (i_sel),
    .o_data  (o_data),
    .o_carry (o_carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [ACC_W-1:0] exp_d, input logic exp_c);
    n_cmp++;
    assert (o_data === exp_d) else begin
      n_fail++;
      $error("FAIL %s o_data observed=%0d expected=%0d", tag, o_data, exp_d);
    end
    n_cmp++;
    assert (o_carry === exp_c) else begin
      n_fail++;
      $error("FAIL %s o_carry observed=%0b expected=%0b", tag, o_carry, exp_c);
    end
  endtask

  // One rising edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset(input string tag);
    i_rst_n = 1'b0;
    #1;
    chk(tag, '0, 1'b0);
    #2;
    i_rst_n = 1'b1;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_data1 = '0;
    i_data2 = '0;
    i_sel   = 2'b11;
    #3;
    chk("reset_init", 6'd0, 1'b0);
    tick();
    chk("reset_held", 6'd0, 1'b0);
    i_rst_n = 1'b1;

    // Sum mode: 3 per edge.
    i_data1 = 3'd1; i_data2 = 3'd2; i_sel = 2'b00;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("sum_e%0d", k), 6'(3 * k), 1'b0);
    end

    async_reset("reset_mid_sum");

    i_sel = 2'b01;
    for (int k = 0; k < 5; k++) tick();
    chk("sel_d1_5", 6'd5, 1'b0);

    async_reset("reset_mid_d1");

    i_sel = 2'b10;
    for (int k = 0; k < 5; k++) tick();
    chk("sel_d2_5", 6'd10, 1'b0);

    i_sel = 2'b11;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("hold_e%0d", k), 6'd10, 1'b0);
    end

    async_reset("reset_before_ovf");

    // 14 per edge: 14, 28, 42, 56, then 70 overflows.
    i_data1 = 3'd7; i_data2 = 3'd7; i_sel = 2'b00;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("ovf_e%0d", k), 6'(14 * k), 1'b0);
    end
`ifdef UNS_ACC_SAT_EN
    tick(); chk("sat_e5", 6'd63, 1'b1);
    tick(); chk("sat_e6", 6'd63, 1'b1);
    tick(); chk("sat_e7", 6'd63, 1'b1);
    i_sel = 2'b11;
    tick(); chk("sat_hold", 6'd63, 1'b0);
`else
    tick(); chk("wrap_e5", 6'd6, 1'b1);
    tick(); chk("wrap_e6", 6'd20, 1'b0);
    tick(); chk("wrap_e7", 6'd34, 1'b0);
    tick(); chk("wrap_e8", 6'd48, 1'b0);
    tick(); chk("wrap_e9", 6'd62, 1'b0);
    tick(); chk("wrap_e10", 6'd12, 1'b1);
    i_sel = 2'b11;
    tick(); chk("wrap_hold", 6'd12, 1'b0);
    // 12 + 7 via data2 alone.
    i_sel = 2'b10;
    tick(); chk("wrap_d2", 6'd19, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
